// File: rtl/vector_load_unit.sv
// Five-element vector load: fetches elements from memory one at a time, then writes the vector register in one cycle.
// Optional feature macro VLU_STRIDE_EN: use the latched stride input instead of a fixed 4-byte element step.
module vector_load_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [3:0]        vd,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              vwe,
  output logic [3:0]        vd2,
  output logic [DATA_W-1:0] wd2_0,
  output logic [DATA_W-1:0] wd2_1,
  output logic [DATA_W-1:0] wd2_2,
  output logic [DATA_W-1:0] wd2_3,
  output logic [DATA_W-1:0] wd2_4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned NUM_ELEM = 5;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_vd;
  logic [3:0]        r_vd2;
  logic [DATA_W-1:0] r_elem [NUM_ELEM];
  logic [ADDR_W-1:0] w_stride;
  logic [ADDR_W-1:0] w_offset;
  logic              w_accept;
  logic              w_capture;
  logic              w_last;

`ifdef VLU_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stride <= '0;
    end else if (w_accept) begin
      r_stride <= stride;
    end
  end

  assign w_stride = r_stride;
`else
  logic w_unused_stride;

  assign w_unused_stride = ^stride;
  assign w_stride        = ADDR_W'(4);
`endif

  // Address is a pure function of latched state, so it stays put across stalls and is never X.
  assign w_offset = ADDR_W'(r_idx) * w_stride;
  assign mem_addr = r_base + w_offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_re    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    vwe       = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        w_accept = start;
        if (start) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        mem_re    = 1'b1;
        w_capture = mem_ready;
        w_last    = mem_ready && (r_idx == 3'd4);
        if (w_last) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        done   = 1'b1;
        vwe    = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_base <= '0;
      r_vd   <= '0;
      r_vd2  <= '0;
      for (int unsigned i = 0; i < NUM_ELEM; i++) begin
        r_elem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_idx  <= '0;
        r_base <= base_addr;
        r_vd   <= vd;
      end
      if (w_capture) begin
        r_idx <= r_idx + 3'd1;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
          if (r_idx == 3'(i)) begin
            r_elem[i] <= mem_rdata;
          end
        end
      end
      // Destination number is published only once the vector is complete, so vd2 holds through the next load.
      if (w_last) begin
        r_vd2 <= r_vd;
      end
    end
  end

  assign vd2   = r_vd2;
  assign wd2_0 = r_elem[0];
  assign wd2_1 = r_elem[1];
  assign wd2_2 = r_elem[2];
  assign wd2_3 = r_elem[3];
  assign wd2_4 = r_elem[4];

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: expected addresses/elements queued at start, checked as the DUT reads and writes.
module tb_vector_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [3:0]  vd;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        vwe;
  logic [3:0]  vd2;
  logic [31:0] wd2_0, wd2_1, wd2_2, wd2_3, wd2_4;
  logic [31:0] wd_arr [5];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  vector_load_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .vd(vd), .mem_re(mem_re), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .vwe(vwe), .vd2(vd2),
    .wd2_0(wd2_0), .wd2_1(wd2_1), .wd2_2(wd2_2), .wd2_3(wd2_3), .wd2_4(wd2_4)
  );

  always #5 clk = ~clk;

  // Memory returns its own address as data.
  assign mem_rdata = mem_addr;

  always_comb begin
    wd_arr[0] = wd2_0;
    wd_arr[1] = wd2_1;
    wd_arr[2] = wd2_2;
    wd_arr[3] = wd2_3;
    wd_arr[4] = wd2_4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // Drives one load from cycle N (start) and checks every read and the write cycle against the scoreboard.
  task automatic run_load(input logic [31:0] base, input logic [31:0] strd, input logic [3:0] vdn,
                          input int stall_at, input bit poke, input int exp_wr);
    logic [31:0] eff;
    logic [31:0] exp_last;
    bit seen;
`ifdef VLU_STRIDE_EN
    eff = strd;
`else
    eff = 32'd4;
`endif
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < 5; i++) begin
      q_addr.push_back(base + 32'(i) * eff);
      q_data.push_back(base + 32'(i) * eff);
    end
    exp_last = base + 32'd4 * eff;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; stride = strd; vd = vdn; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      mem_ready = (c != stall_at);
      if (poke && (c == 2 || c == exp_wr)) begin
        start = 1'b1;
        base_addr = 32'h300;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (mem_re) begin
        n_checks++;
        if (q_addr.size() == 0) begin
          n_errors++;
          $display("FAIL extra_read: cycle %0d addr=%h, none expected", c, mem_addr);
        end else if (mem_addr !== q_addr[0]) begin
          n_errors++;
          $display("FAIL mem_addr: cycle %0d got %h expected %h", c, mem_addr, q_addr[0]);
        end
        if (mem_ready && q_addr.size() != 0) void'(q_addr.pop_front());
      end
      if (vwe) begin
        seen = 1'b1;
        n_checks++;
        if (c != exp_wr) begin
          n_errors++;
          $display("FAIL vwe_cycle: got N+%0d expected N+%0d", c, exp_wr);
        end
        n_checks++;
        if (done !== 1'b1) begin
          n_errors++;
          $display("FAIL done_with_vwe: got %b expected 1", done);
        end
        n_checks++;
        if (vd2 !== vdn) begin
          n_errors++;
          $display("FAIL vd2: got %0d expected %0d", vd2, vdn);
        end
        for (int i = 0; i < 5; i++) begin
          n_checks++;
          if (q_data.size() == 0) begin
            n_errors++;
            $display("FAIL wd2_%0d: got %h, no expected value queued", i, wd_arr[i]);
          end else if (wd_arr[i] !== q_data[0]) begin
            n_errors++;
            $display("FAIL wd2_%0d: got %h expected %h", i, wd_arr[i], q_data[0]);
          end
          if (q_data.size() != 0) void'(q_data.pop_front());
        end
      end else begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_in_load: cycle %0d busy=%b done=%b expected busy=1 done=0", c, busy, done);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL timeout: no vwe within 20 cycles, expected at N+%0d", exp_wr);
    end
    n_checks++;
    if (q_addr.size() != 0) begin
      n_errors++;
      $display("FAIL reads_missing: %0d addresses never read, expected 0", q_addr.size());
    end
    n_checks++;
    if (busy !== 1'b0 || vwe !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL after_write: busy=%b vwe=%b done=%b expected 0 0 0", busy, vwe, done);
    end
    n_checks++;
    if (wd2_4 !== exp_last || vd2 !== vdn) begin
      n_errors++;
      $display("FAIL hold_idle: wd2_4=%h vd2=%0d expected %h %0d", wd2_4, vd2, exp_last, vdn);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; vd = '0; mem_ready = 1'b0;
    #12;
    n_checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0 || vwe !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy=%b mem_re=%b vwe=%b done=%b expected all 0", busy, mem_re, vwe, done);
    end
    n_checks++;
    if (vd2 !== 4'd0 || wd2_0 !== 32'd0 || wd2_4 !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_data: vd2=%0d wd2_0=%h wd2_4=%h expected 0", vd2, wd2_0, wd2_4);
    end
    n_checks++;
    if ($isunknown(mem_addr)) begin
      n_errors++;
      $display("FAIL reset_addr: mem_addr=%h expected known value", mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_contiguous();
    run_load(32'h100, 32'd4, 4'd3, -1, 1'b0, 6);
  endtask

  task automatic test_stall();
    run_load(32'h100, 32'd4, 4'd3, 3, 1'b0, 7);
  endtask

  task automatic test_wrap();
    run_load(32'hFFFF_FFF8, 32'd4, 4'd9, -1, 1'b0, 6);
  endtask

  task automatic test_reset_mid_op();
    bit bad;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h100; stride = 32'd4; vd = 4'd5; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h108) begin
      n_errors++;
      $display("FAIL pre_abort: mem_re=%b addr=%h expected 1 00000108", mem_re, mem_addr);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_immediate: busy=%b mem_re=%b expected 0 0", busy, mem_re);
    end
    n_checks++;
    if (wd2_0 !== 32'd0 || wd2_1 !== 32'd0) begin
      n_errors++;
      $display("FAIL abort_clear: wd2_0=%h wd2_1=%h expected 0", wd2_0, wd2_1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vwe !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL abort_no_write: vwe/done/busy seen high after abort, expected 0");
    end
    run_load(32'h200, 32'd4, 4'd6, -1, 1'b0, 6);
  endtask

  task automatic test_start_while_busy();
    run_load(32'h100, 32'd4, 4'd7, -1, 1'b1, 6);
    run_load(32'h300, 32'd4, 4'd8, -1, 1'b0, 6);
  endtask

  task automatic test_stride();
    run_load(32'h40, 32'h10, 4'd12, -1, 1'b0, 6);
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_stall();
    test_wrap();
    test_reset_mid_op();
    test_start_while_busy();
    test_stride();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
